// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining serial transmitter: state
// encoding, default geometry and frame-length arithmetic.
package fifo_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DATA_BITS_DEF    = 32'd8;
    localparam int unsigned CLKS_PER_BIT_DEF = 32'd16;
    localparam int unsigned STOP_BITS_DEF    = 32'd1;
    localparam int unsigned TICK_W_DEF       = $clog2(CLKS_PER_BIT_DEF);
    localparam int unsigned BIT_W_DEF        = $clog2(DATA_BITS_DEF);

    // Cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int unsigned frame_cycles(input int unsigned data_bits,
                                                 input int unsigned clks_per_bit,
                                                 input int unsigned stop_bits);
        return (32'd1 + data_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Per-bit tick counter: counts 0..CLKS_PER_BIT-1 while a frame runs and
// flags the final cycle of each serial bit.
module bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic run_i,
    output logic bit_end_o
);

    localparam int unsigned       TICK_W   = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_BIT - 32'd1);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    // Next tick value: cleared on a pop or while idle, wraps at the bit end.
    always_comb begin
        tick_d = tick_q;
        if (clr_i) begin
            tick_d = '0;
        end else if (!run_i) begin
            tick_d = '0;
        end else if (tick_q == TICK_MAX) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign bit_end_o = (tick_q == TICK_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// Serial transmit stage draining a first-word-fall-through FIFO: pops one
// word per frame and shifts it out as start / data LSB-first / stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned STOP_BITS    = STOP_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_BITS-1:0] fifo_rdata_i,
    output logic                 fifo_rd_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 tx_done_tick_o
);

    localparam int unsigned      BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 32'd1);
    localparam logic             STOP_LAST = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 tx_q;
    logic                 busy_q;

    logic                 bit_end_s;
    logic                 last_stop_s;
    logic                 pop_s;
    logic [DATA_BITS-1:0] shift_next_s;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (pop_s),
        .run_i     (state_q != ST_IDLE),
        .bit_end_o (bit_end_s)
    );

    // The pop is Mealy so a waiting word is taken in the very cycle the
    // final stop bit ends, giving gapless back-to-back frames.
    assign last_stop_s  = (state_q == ST_STOP) && bit_end_s && (stop_cnt_q == STOP_LAST);
    assign pop_s        = tx_en_i && !fifo_empty_i && ((state_q == ST_IDLE) || last_stop_s);
    assign shift_next_s = shift_q >> 1;

    // Frame sequencer with registered line, busy flag, shifter and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else if (pop_s) begin
            state_q    <= ST_START;
            shift_q    <= fifo_rdata_i;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        shift_q <= shift_next_s;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q    <= ST_STOP;
                            stop_cnt_q <= 1'b0;
                            tx_q       <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            tx_q      <= shift_next_s[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            state_q    <= ST_IDLE;
                            stop_cnt_q <= 1'b0;
                            tx_q       <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_o      = pop_s;
    assign tx_o           = tx_q;
    assign busy_o         = busy_q;
    assign tx_done_tick_o = last_stop_s;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT, expected
// serial frames are queued at stimulus time and checked cycle by cycle.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int CPB = 4;

    typedef struct {
        logic [10:0] bits;   // bit i = i-th bit on the line (start first)
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       sel;
    logic       model_empty;
    logic [7:0] model_rdata;
    logic       empty1, empty2;
    logic       rd1, tx1, busy1, done1;
    logic       rd2, tx2, busy2, done2;
    logic       rd_m, tx_m, busy_m, done_m, empty_m;

    frame_t     exp_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         pops  = 0;
    int         cyc_n = 0;
    bit         pop_now;
    bit         busy_now;

    assign empty1  = sel ? 1'b1 : model_empty;
    assign empty2  = sel ? model_empty : 1'b1;
    assign rd_m    = sel ? rd2   : rd1;
    assign tx_m    = sel ? tx2   : tx1;
    assign busy_m  = sel ? busy2 : busy1;
    assign done_m  = sel ? done2 : done1;
    assign empty_m = sel ? empty2 : empty1;

    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .tx_en_i(tx_en), .fifo_empty_i(empty1),
        .fifo_rdata_i(model_rdata), .fifo_rd_o(rd1), .tx_o(tx1),
        .busy_o(busy1), .tx_done_tick_o(done1)
    );

    fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .tx_en_i(tx_en), .fifo_empty_i(empty2),
        .fifo_rdata_i(model_rdata), .fifo_rd_o(rd2), .tx_o(tx2),
        .busy_o(busy2), .tx_done_tick_o(done2)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic upd();
        model_empty = (fifo_q.size() == 0);
        model_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // One clock: sample the pop mid-cycle, then update the FIFO model after the edge.
    task automatic cyc();
        logic [7:0] dummy;
        @(negedge clk);
        pop_now  = rd_m && !reset;
        busy_now = busy_m;
        @(posedge clk);
        #1;
        cyc_n++;
        if (pop_now && fifo_q.size() != 0) begin
            dummy = fifo_q.pop_front();
            pops++;
            pop_cyc.push_back(cyc_n);
        end
        upd();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic expect_frame(input logic [10:0] bits, input int nbits);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        exp_q.push_back(f);
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        upd();
    endtask

    task automatic frame_mon(input frame_t f, output bit more);
        int len;
        len  = f.nbits * CPB;
        more = 1'b0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (reset) return;
            check($sformatf("tx_bit c%0d", c), tx_m, f.bits[(c - 1) / CPB]);
            check($sformatf("busy_in_frame c%0d", c), busy_m, 1);
            check($sformatf("done_tick c%0d", c), done_m, (c == len));
            if (c < len) check($sformatf("rd_in_frame c%0d", c), rd_m, 0);
            else         more = rd_m;
        end
    endtask

    // Monitor: idle line checks, then a full frame check on every pop.
    initial begin : monitor
        frame_t f;
        bit     more;
        forever begin
            @(negedge clk);
            if (reset) continue;
            check("idle_tx", tx_m, 1);
            check("idle_busy", busy_m, 0);
            check("idle_done", done_m, 0);
            if (rd_m) begin
                more = 1'b1;
                while (more) begin
                    more = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pop: got rd=1 expected no pop at %0t", $time);
                    end else begin
                        f = exp_q.pop_front();
                        frame_mon(f, more);
                    end
                end
            end
        end
    end

    initial begin : empty_guard
        forever begin
            @(negedge clk);
            check("rd_while_empty", rd_m & empty_m, 0);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int p0;
        int busy_lo;
        reset = 1'b1; tx_en = 1'b0; sel = 1'b0;
        upd();
        run(2);
        check("rst_tx", tx_m, 1);
        check("rst_busy", busy_m, 0);
        check("rst_rd", rd_m, 0);
        check("rst_done", done_m, 0);
        reset = 1'b0; tx_en = 1'b1;

        // Empty FIFO stays idle; one-cycle reset pulse while idle.
        run(100);
        check("s1_pops", pops, 0);
        reset = 1'b1;
        #1;
        check("s1_pulse_tx", tx_m, 1);
        check("s1_pulse_busy", busy_m, 0);
        run(1);
        reset = 1'b0;
        run(2);

        // Single word 0xA5.
        expect_frame(11'b01101001010, 10); load(8'hA5);
        cyc();
        check("s2_rd_same_cycle", pop_now, 1);
        run(frame_cycles(8, CPB, 1) + 5);
        check("s2_pops", pops, 1);

        // Back-to-back 0x00, 0xFF.
        p0 = pop_cyc.size();
        expect_frame(11'b01000000000, 10); load(8'h00);
        expect_frame(11'b01111111110, 10); load(8'hFF);
        cyc();
        check("s3_rd_first", pop_now, 1);
        busy_lo = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (!busy_now) busy_lo++;
        end
        check("s3_busy_gap", busy_lo, 0);
        check("s3_pops", pops, 3);
        check("s3_pop_spacing", pop_cyc[p0 + 1] - pop_cyc[p0], 40);
        run(5);

        // tx_en gating: held word, then drop tx_en during data bit 2.
        tx_en = 1'b0;
        load(8'h3C);
        run(200);
        check("s4_no_pop_disabled", pops, 3);
        tx_en = 1'b1;
        expect_frame(11'b01001111000, 10);
        cyc();
        check("s4_rd_on_enable", pop_now, 1);
        load(8'hC3);
        run(12);
        tx_en = 1'b0;
        run(45);
        check("s4_no_second_pop", pops, 4);
        check("s4_word_held", fifo_q.size(), 1);
        expect_frame(11'b01110000110, 10);
        tx_en = 1'b1;
        run(45);
        check("s4_second_sent", pops, 5);

        // Reset during data bit 3.
        expect_frame(11'b01010110100, 10); load(8'h5A);
        cyc();
        check("s5_rd", pop_now, 1);
        run(17);
        reset = 1'b1;
        fifo_q.delete();
        upd();
        #1;
        check("s5_async_tx", tx_m, 1);
        check("s5_async_busy", busy_m, 0);
        run(1);
        reset = 1'b0;
        run(50);
        check("s5_pops", pops, 6);
        check("s5_busy_after", busy_m, 0);
        check("s5_exp_drained", exp_q.size(), 0);

        // Two stop bits, word 0x81.
        sel = 1'b1;
        run(2);
        expect_frame(11'b11100000010, 11); load(8'h81);
        cyc();
        check("s6_rd", pop_now, 1);
        run(frame_cycles(8, CPB, 2) + 5);
        check("s6_pops", pops, 7);
        check("all_frames_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the FIFO built around `fifo_ctrl`. It sits directly downstream of the FIFO read port: it watches `empty`, pops one word at a time, and shifts each word out as an 8N1-style asynchronous serial frame (start bit, data LSB first, stop bit(s)). Frames run back-to-back while data is available. The line idles high otherwise.

## Interface
- `DATA_BITS`, default 8: word width; must match FIFO data width.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Legal range is ≥2.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `tx_en` in 1: permits starting a new frame. A frame already in progress always completes.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_rdata` in DATA_BITS: FIFO head word. It is valid whenever `fifo_empty`=0 (memory read at `r_addr`, first-word fall-through).
- `fifo_rd` out 1: pop strobe to FIFO `rd`. Asserted for exactly one cycle per word.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).
- `tx_done_tick` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift_reg[0].
  - STOP: `tx`=1.
- Pop condition (combinational, Mealy): `fifo_rd` = `tx_en` & ~`fifo_empty` & (state==IDLE | last cycle of final stop bit).
- On a pop edge:
  - shift_reg ← `fifo_rdata`.
  - Tick counter ← 0.
  - State ← START.
  - `tx` register ← 0.
- Tick counter runs 0..CLKS_PER_BIT-1. Reaching CLKS_PER_BIT-1 ends the current bit.
- START end: go to DATA with bit counter 0.
- DATA bit end:
  - Shift right by one.
  - Increment the bit counter.
  - After bit DATA_BITS-1, go to STOP.
- STOP: lasts STOP_BITS×CLKS_PER_BIT cycles. At the end:
  - If the pop condition holds, go directly to START with the new word (no idle cycle).
  - Otherwise go to IDLE.
- `tx_done_tick` fires on every completed frame, including back-to-back frames.
- Deasserting `tx_en` mid-frame has no effect on that frame. It only suppresses the next pop.
- `fifo_rd` is never asserted while `fifo_empty`=1. The FIFO's simultaneous rd/wr case therefore never sees an illegal read.
- Widths:
  - Tick counter: $clog2(CLKS_PER_BIT).
  - Bit counter: $clog2(DATA_BITS).
  - Stop counter: 1 bit when STOP_BITS=2.
  - Counters never wrap past their terminal value.

## Timing
- Reset values: state IDLE, `tx`=1, `busy`=0, `fifo_rd`=0, `tx_done_tick`=0, all counters 0, shift_reg 0.
- Reset mid-frame: `tx` returns high asynchronously and the word is lost. The FIFO is reset by the same signal.
- Latency: `fifo_empty` falls in cycle N (IDLE, `tx_en`=1), so `fifo_rd`=1 in cycle N. `tx`=0 from cycle N+1.
- Frame length: (1+DATA_BITS+STOP_BITS)×CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- `busy` is high from N+1 through the last STOP cycle. It stays high continuously across back-to-back frames.
- `tx` changes only on clk edges and is glitch-free.

## Structure
- Shared package `fifo_uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - width localparams derived from the parameters;
  - a frame-length constant function used by the bench.
- One sub-module, `bit_timer`:
  - Holds the tick counter with a synchronous clear on pop.
  - Outputs `bit_end` when count==CLKS_PER_BIT-1.
  - Parameter: CLKS_PER_BIT.
- FSM, shift register and bit/stop counters live in the top module.

## Test plan
All scenarios use DATA_BITS=8, CLKS_PER_BIT=4, STOP_BITS=1 unless noted.
1. Reset with FIFO empty → `tx`=1, `busy`=0, `fifo_rd`=0, no pops over 100 cycles. Assert `reset` for one cycle at any time → same values immediately.
2. Single word 0xA5, `tx_en`=1 → `fifo_rd` pulse exactly 1 cycle. Then `tx` = 0 (4 cycles), followed by bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1. Frame is 40 cycles with one `tx_done_tick` in cycle 40.
3. Words 0x00 then 0xFF preloaded → second `fifo_rd` in cycle 40 of the first frame. Zero idle cycles, 80 cycles total, two `tx_done_tick`s, `busy` never drops between frames.
4. FIFO holds 0x3C, `tx_en`=0 → no `fifo_rd` for 200 cycles. Raise `tx_en` → frame starts next cycle. Drop `tx_en` at data bit 2 with a second word queued → frame completes and no second pop occurs.
5. Reset asserted during data bit 3 → `tx`=1 and `busy`=0 asynchronously. After release with FIFO empty, block stays IDLE.
6. STOP_BITS=2, word 0x81 → stop high for 8 cycles, frame 44 cycles, `tx_done_tick` in cycle 44.
